// File: rtl/fx2_stream_writer_if.sv
// Stream-side handshake and FX2 slave-FIFO write port of fx2_stream_writer.
// The writer uses the master modport; the upstream source / FX2 model uses slave.
interface fx2_stream_writer_if;
    logic [15:0] DATA_IN;
    logic        DATA_VALID;
    logic        DATA_READY;
    logic        FLUSH_REQ;
    logic        FX2_FULL_N;
    logic        FX2_RDY;
    logic        SLWR_N;
    logic [15:0] FIFODATA;
    logic [1:0]  FIFOADDR;
    logic        PKTEND_N;
    logic [31:0] TOTAL_WORDS;

    modport master (
        input  DATA_IN, DATA_VALID, FLUSH_REQ, FX2_FULL_N, FX2_RDY,
        output DATA_READY, SLWR_N, FIFODATA, FIFOADDR, PKTEND_N, TOTAL_WORDS
    );

    modport slave (
        output DATA_IN, DATA_VALID, FLUSH_REQ, FX2_FULL_N, FX2_RDY,
        input  DATA_READY, SLWR_N, FIFODATA, FIFOADDR, PKTEND_N, TOTAL_WORDS
    );
endinterface

// File: rtl/fx2_stream_writer.sv
// Writes accepted 16-bit stream words into the FX2 slave FIFO and commits short
// packets with PKTEND_N after an idle timeout or a host flush request.
module fx2_stream_writer #(
    parameter int         PKT_WORDS = 256,
    parameter int         TIMEOUT   = 1023,
    parameter logic [1:0] EP_ADDR   = 2'b10
) (
    input  logic                  STREAM_CLK,
    input  logic                  STREAM_RST,
    fx2_stream_writer_if.master   fx2
);
    localparam int             CW       = $clog2(PKT_WORDS);
    localparam logic [CW-1:0]  CNT_LAST = CW'(PKT_WORDS - 1);
    localparam logic [15:0]    IDLE_MAX = 16'(TIMEOUT);

    localparam logic [1:0] ST_STREAM = 2'd0;
    localparam logic [1:0] ST_FLUSH  = 2'd1;
    localparam logic [1:0] ST_GAP    = 2'd2;

    logic [1:0]    state_q, state_d;
    logic          ok_q;
    logic [CW-1:0] word_cnt_q, word_cnt_d;
    logic [15:0]   idle_cnt_q, idle_cnt_d;
    logic          flush_pend_q, flush_pend_d;
    logic          slwr_n_q, slwr_n_d;
    logic          pktend_n_q, pktend_n_d;
    logic [15:0]   fifodata_q, fifodata_d;
    logic [31:0]   total_q, total_d;

    logic ready, xfer, cnt_nz, wrap, go_flush;

    assign ready  = (state_q == ST_STREAM) && ok_q;
    assign xfer   = fx2.DATA_VALID && ready;
    assign cnt_nz = (word_cnt_q != '0);
    assign wrap   = xfer && (word_cnt_q == CNT_LAST);
    // An incoming word always wins over a commit; the commit is retried on the next idle cycle.
    assign go_flush = (state_q == ST_STREAM) && cnt_nz && ok_q && !xfer
                      && ((idle_cnt_q == IDLE_MAX) || flush_pend_q);

    // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        state_d      = state_q;
        word_cnt_d   = word_cnt_q;
        idle_cnt_d   = idle_cnt_q;
        flush_pend_d = flush_pend_q;
        slwr_n_d     = !xfer;
        pktend_n_d   = !go_flush;
        fifodata_d   = xfer ? fx2.DATA_IN : fifodata_q;
        total_d      = total_q + 32'(xfer);

        case (state_q)
            ST_STREAM: if (go_flush) state_d = ST_FLUSH;
            ST_FLUSH:  state_d = ST_GAP;
            ST_GAP:    state_d = ST_STREAM;
            default:   state_d = ST_STREAM;
        endcase

        if (xfer)
            word_cnt_d = word_cnt_q + 1'b1;
        else if (state_q == ST_FLUSH)
            word_cnt_d = '0;

        if (xfer || (state_q == ST_FLUSH) || !cnt_nz)
            idle_cnt_d = '0;
        else if (idle_cnt_q != IDLE_MAX)
            idle_cnt_d = idle_cnt_q + 16'd1;

        // A flush landing on the auto-commit word is dropped: no zero-length packet follows.
        if (go_flush || wrap)
            flush_pend_d = 1'b0;
        else if (fx2.FLUSH_REQ && (cnt_nz || xfer))
            flush_pend_d = 1'b1;
    end

    // NOTE: sequential state is written only with non-blocking assignments, so every register samples pre-edge values.
    always_ff @(posedge STREAM_CLK or posedge STREAM_RST) begin
        if (STREAM_RST) begin
            state_q      <= ST_STREAM;
            ok_q         <= 1'b0;
            word_cnt_q   <= '0;
            idle_cnt_q   <= '0;
            flush_pend_q <= 1'b0;
            slwr_n_q     <= 1'b1;
            pktend_n_q   <= 1'b1;
            fifodata_q   <= '0;
            total_q      <= '0;
        end else begin
            state_q      <= state_d;
            ok_q         <= fx2.FX2_FULL_N && fx2.FX2_RDY;
            word_cnt_q   <= word_cnt_d;
            idle_cnt_q   <= idle_cnt_d;
            flush_pend_q <= flush_pend_d;
            slwr_n_q     <= slwr_n_d;
            pktend_n_q   <= pktend_n_d;
            fifodata_q   <= fifodata_d;
            total_q      <= total_d;
        end
    end

    assign fx2.DATA_READY  = ready;
    assign fx2.SLWR_N      = slwr_n_q;
    assign fx2.FIFODATA    = fifodata_q;
    assign fx2.FIFOADDR    = EP_ADDR;
    assign fx2.PKTEND_N    = pktend_n_q;
    assign fx2.TOTAL_WORDS = total_q;
endmodule

// File: tb/tb_fx2_stream_writer.sv
// Bench for fx2_stream_writer: vector table, directed packet/flush/full/reset
// sequences and a randomized run against a cycle-level reference model.
module tb_fx2_stream_writer;
    localparam int PKT = 256;
    localparam int TO  = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    fx2_stream_writer_if bus();

    fx2_stream_writer #(.PKT_WORDS(PKT), .TIMEOUT(TO), .EP_ADDR(2'b10)) dut (
        .STREAM_CLK (clk),
        .STREAM_RST (rst),
        .fx2        (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Output monitor: counts strobes and packet ends, captures written data.
    int          mon_wr = 0, mon_pkt = 0, mon_both = 0, mon_pkt_cyc = -1;
    int          ready_bad = 0, gap_bad = 0;
    logic        pkt_prev = 1'b0;
    logic [15:0] cap_q[$];

    always @(negedge clk) begin
        if (!rst) begin
            if (!bus.SLWR_N) begin
                mon_wr <= mon_wr + 1;
                cap_q.push_back(bus.FIFODATA);
            end
            if (!bus.PKTEND_N) begin
                mon_pkt     <= mon_pkt + 1;
                mon_pkt_cyc <= cyc;
                if (bus.DATA_READY) ready_bad <= ready_bad + 1;
            end
            if (!bus.PKTEND_N && !bus.SLWR_N) mon_both <= mon_both + 1;
            if (pkt_prev && (bus.DATA_READY || !bus.SLWR_N || !bus.PKTEND_N)) gap_bad <= gap_bad + 1;
            pkt_prev <= !bus.PKTEND_N;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic drive(input bit v, input logic [15:0] d, input bit f, input bit fn, input bit rd);
        bus.DATA_VALID = v;
        bus.DATA_IN    = d;
        bus.FLUSH_REQ  = f;
        bus.FX2_FULL_N = fn;
        bus.FX2_RDY    = rd;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        drive(0, 16'h0, 0, 1, 1);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        drive(0, 16'h0, 0, 1, 1);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Sends n consecutive words starting at base; FLUSH_REQ rides on word index flush_at.
    task automatic send_words(input int n, input logic [15:0] base, input int flush_at, output int t_last);
        int sent   = 0;
        int budget = 0;
        t_last = -1;
        while (sent < n && budget < 4 * n + 50) begin
            drive(1, base + 16'(sent), sent == flush_at, 1, 1);
            #1;
            if (bus.DATA_READY === 1'b1) begin
                sent++;
                t_last = cyc;
            end
            tick();
            budget++;
        end
        drive(0, 16'h0, 0, 1, 1);
        check("send_done", 64'(sent), 64'(n));
    endtask

    typedef struct {
        bit          v;
        logic [15:0] d;
        bit          f;
        bit          fn;
        bit          exp_rdy;
        bit          exp_slwr_n;
        bit          exp_pkt_n;
        logic [15:0] exp_d;
    } vec_t;

    vec_t tbl[13];

    // Reference model state (random phase)
    bit          m_ok, m_wr, m_pend;
    int          m_phase, m_fill, m_idle;
    logic [15:0] m_last;
    logic [31:0] m_total;

    initial begin
        int t, t0, w0, p0, c0, seq, acc_full, rdy_err, bad, found, vprob;
        bit fn, exp_r;

        drive(0, 16'h0, 0, 1, 1);
        @(negedge clk);
        do_reset();
        #1;
        check("reset_state",
              64'({bus.DATA_READY, bus.SLWR_N, bus.PKTEND_N, bus.FIFODATA, bus.TOTAL_WORDS, bus.FIFOADDR}),
              64'({1'b0, 1'b1, 1'b1, 16'h0000, 32'd0, 2'b10}));

        // Vector table: flush at count 0, 3 words with flush on the 3rd, FLUSH/GAP, full flag lag.
        tbl[0]  = '{0, 16'h0000, 1, 1, 0, 1, 1, 16'h0000};
        tbl[1]  = '{1, 16'h1111, 0, 1, 1, 1, 1, 16'h0000};
        tbl[2]  = '{1, 16'h2222, 0, 1, 1, 0, 1, 16'h1111};
        tbl[3]  = '{1, 16'h3333, 1, 1, 1, 0, 1, 16'h2222};
        tbl[4]  = '{0, 16'h0000, 0, 1, 1, 0, 1, 16'h3333};
        tbl[5]  = '{1, 16'hBBBB, 0, 1, 0, 1, 0, 16'h3333};
        tbl[6]  = '{1, 16'hBBBB, 0, 1, 0, 1, 1, 16'h3333};
        tbl[7]  = '{1, 16'hBBBB, 0, 1, 1, 1, 1, 16'h3333};
        tbl[8]  = '{0, 16'h0000, 0, 0, 1, 0, 1, 16'hBBBB};
        tbl[9]  = '{1, 16'hCCCC, 0, 1, 0, 1, 1, 16'hBBBB};
        tbl[10] = '{1, 16'hCCCC, 0, 1, 1, 1, 1, 16'hBBBB};
        tbl[11] = '{0, 16'h0000, 0, 1, 1, 0, 1, 16'hCCCC};
        tbl[12] = '{0, 16'h0000, 0, 1, 1, 1, 1, 16'hCCCC};
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].v, tbl[i].d, tbl[i].f, tbl[i].fn, 1);
            #1;
            check($sformatf("vec%0d", i),
                  64'({bus.DATA_READY, bus.SLWR_N, bus.PKTEND_N, bus.FIFODATA}),
                  64'({tbl[i].exp_rdy, tbl[i].exp_slwr_n, tbl[i].exp_pkt_n, tbl[i].exp_d}));
            tick();
        end
        check("vec_total", 64'(bus.TOTAL_WORDS), 64'd5);

        // 512 back-to-back words; flush at count 0 and on the 256th (wrap) word.
        do_reset();
        drive(0, 16'h0, 1, 1, 1);
        tick();
        w0 = mon_wr; p0 = mon_pkt; c0 = cap_q.size(); t0 = cyc;
        send_words(512, 16'h0000, 255, t);
        idle(40);
        check("burst_cycles", 64'(t - t0), 64'd511);
        check("burst_writes", 64'(mon_wr - w0), 64'd512);
        check("burst_no_pktend", 64'(mon_pkt - p0), 64'd0);
        bad = 0;
        for (int i = 0; i < 512; i++)
            if (c0 + i >= cap_q.size() || cap_q[c0 + i] !== 16'(i)) bad++;
        check("burst_data_order", 64'(bad), 64'd0);
        check("burst_total", 64'(bus.TOTAL_WORDS), 64'd512);

        // Idle timeout: 3 words, PKTEND TIMEOUT+2 cycles after the last accept, only once.
        do_reset();
        tick();
        p0 = mon_pkt;
        send_words(3, 16'h0100, -1, t);
        idle(60);
        check("timeout_pkt_count", 64'(mon_pkt - p0), 64'd1);
        check("timeout_latency", 64'(mon_pkt_cyc - t), 64'(TO + 2));

        // Flush coincident with the 11th word.
        p0 = mon_pkt;
        send_words(11, 16'h0200, 10, t);
        idle(6);
        check("flush_pkt_count", 64'(mon_pkt - p0), 64'd1);
        check("flush_latency", 64'(mon_pkt_cyc - t), 64'd2);

        // FX2 full for 8 cycles mid-burst.
        w0 = mon_wr; c0 = cap_q.size();
        seq = 0; acc_full = 0; rdy_err = 0;
        for (int k = 0; k < 40; k++) begin
            fn = !(k >= 10 && k < 18);
            exp_r = !(k >= 11 && k < 19);
            drive(1, 16'h4000 + 16'(seq), 0, fn, 1);
            #1;
            if (bus.DATA_READY !== exp_r) rdy_err++;
            if (bus.DATA_READY === 1'b1) begin
                if (k >= 10 && k < 18) acc_full++;
                seq++;
            end
            tick();
        end
        idle(3);
        check("full_ready_pattern", 64'(rdy_err), 64'd0);
        check("full_writes_after_edge", 64'(acc_full), 64'd1);
        check("full_write_count", 64'(mon_wr - w0), 64'(seq));
        bad = 0;
        for (int i = 0; i < seq; i++)
            if (c0 + i >= cap_q.size() || cap_q[c0 + i] !== 16'h4000 + 16'(i)) bad++;
        check("full_data_integrity", 64'(bad), 64'd0);

        // Reset asserted while in FLUSH with 5 words in the packet.
        do_reset();
        tick();
        send_words(5, 16'h0300, 4, t);
        found = 0;
        for (int i = 0; i < 6 && found == 0; i++) begin
            if (bus.PKTEND_N === 1'b0) found = 1;
            else tick();
        end
        check("rst_reached_flush", 64'(found), 64'd1);
        rst = 1'b1;
        #1;
        check("rst_async_outputs",
              64'({bus.DATA_READY, bus.SLWR_N, bus.PKTEND_N, bus.FIFODATA, bus.TOTAL_WORDS}),
              64'({1'b0, 1'b1, 1'b1, 16'h0000, 32'd0}));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        w0 = mon_wr; p0 = mon_pkt;
        send_words(256, 16'h0500, -1, t);
        idle(40);
        check("rst_next_pkt_writes", 64'(mon_wr - w0), 64'd256);
        check("rst_next_pkt_no_pktend", 64'(mon_pkt - p0), 64'd0);

        // Randomized run against the reference model.
        do_reset();
        m_ok = 0; m_wr = 0; m_pend = 0; m_phase = 0; m_fill = 0; m_idle = 0;
        m_last = 16'h0; m_total = 32'd0;
        vprob = 90;
        bad = 0;
        for (int n = 0; n < 3000; n++) begin
            bit v, f, rd, xfer, commit, exp_rdy;
            logic [15:0] d;
            if (n % 64 == 0) begin
                case ($urandom_range(2))
                    0:       vprob = 95;
                    1:       vprob = 60;
                    default: vprob = 3;
                endcase
            end
            v  = ($urandom_range(99) < vprob);
            d  = 16'($urandom);
            f  = ($urandom_range(39) == 0);
            fn = ($urandom_range(11) != 0);
            rd = ($urandom_range(24) != 0);
            drive(v, d, f, fn, rd);
            #1;
            exp_rdy = (m_phase == 0) && m_ok;
            if ({bus.DATA_READY, bus.SLWR_N, bus.PKTEND_N, bus.FIFODATA, bus.TOTAL_WORDS} !==
                {exp_rdy, !m_wr, m_phase != 1, m_last, m_total}) begin
                bad++;
                if (bad <= 5)
                    check($sformatf("rand_cycle%0d", n),
                          64'({bus.DATA_READY, bus.SLWR_N, bus.PKTEND_N, bus.FIFODATA, bus.TOTAL_WORDS}),
                          64'({exp_rdy, !m_wr, m_phase != 1, m_last, m_total}));
            end
            xfer   = v && exp_rdy;
            commit = (m_phase == 0) && (m_fill != 0) && (m_idle >= TO || m_pend) && m_ok && !xfer;
            if (xfer) begin
                m_wr = 1; m_last = d; m_total++; m_fill++; m_idle = 0;
                if (m_fill == PKT) begin
                    m_fill = 0;
                    m_pend = 0;
                end else if (f) m_pend = 1;
            end else begin
                m_wr = 0;
                if (commit) m_pend = 0;
                else if (f && m_fill != 0) m_pend = 1;
                if (m_phase == 1) begin
                    m_fill = 0;
                    m_idle = 0;
                end else if (m_fill == 0) m_idle = 0;
                else if (m_idle < TO) m_idle++;
            end
            m_phase = commit ? 1 : (m_phase == 1 ? 2 : 0);
            m_ok = fn && rd;
            tick();
        end
        idle(4);
        check("rand_model_mismatches", 64'(bad), 64'd0);
        check("rand_words_moved", 64'(m_total > 500), 64'd1);

        check("never_pktend_with_slwr", 64'(mon_both), 64'd0);
        check("quiet_cycle_after_pktend", 64'(gap_bad), 64'd0);
        check("ready_low_in_flush", 64'(ready_bad), 64'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/fx2_stream_writer.md
# fx2_stream_writer

Downstream stage of the SRAM stream FIFO. Accepts 16-bit words over a valid/ready handshake in the USB stream clock domain and drives the FX2 slave-FIFO write port (SLWR_N, FIFODATA, FIFOADDR, PKTEND_N). It commits short packets via PKTEND_N on an idle timeout or on a host flush request, so trailing TLU words reach the host without waiting for a full 512-byte packet. It replaces the tied-off PKTEND_N / FIFOADDR logic in the top level.

## Interface
- PKT_WORDS, 256: words per full USB packet (FX2 auto-commit size). Power of two, 2..1024.
- TIMEOUT, 1023: idle STREAM_CLK cycles with a partial packet before an automatic PKTEND. Range 1..65535.
- EP_ADDR, 2'b10: constant value driven on FIFOADDR.

Ports:
- STREAM_CLK  in  1  stream clock. One clock only: USB_STREAM_CLK, 48 MHz.
- STREAM_RST  in  1  asynchronous, active-high reset.
- DATA_IN  in  16  upstream word.
- DATA_VALID  in  1  DATA_IN valid.
- DATA_READY  out  1  block accepts a word this cycle.
- FLUSH_REQ  in  1  single-cycle pulse requesting commit of a partial packet.
- FX2_FULL_N  in  1  FX2 full flag (FLAGS_N[1]); 0 = full.
- FX2_RDY  in  1  FX2 ready.
- SLWR_N  out  1  FX2 write strobe, active low, registered (IOB).
- FIFODATA  out  16  FX2 data, registered (IOB).
- FIFOADDR  out  2  endpoint select, constant EP_ADDR.
- PKTEND_N  out  1  FX2 packet end, active low, registered.
- TOTAL_WORDS  out  32  words written since reset; wraps at 2^32.

## Operation
- Input sampling: `ok_q` is registered each cycle as FX2_FULL_N & FX2_RDY.
- Accept rule: DATA_READY = (state == STREAM) & ok_q. A transfer occurs on a rising edge where DATA_VALID & DATA_READY are both high.
- Write: on a transfer, the next cycle drives SLWR_N=0 and FIFODATA=DATA_IN. With no transfer, SLWR_N=1 and FIFODATA holds its last value. Back-to-back transfers produce one write per cycle.
- `word_cnt` (log2(PKT_WORDS) bits): increments on each transfer and wraps to 0 after PKT_WORDS-1. At wrap, the FX2 auto-commits and no PKTEND is issued.
- `idle_cnt` (16 bit):
  - clears on every transfer;
  - increments while word_cnt != 0 and no transfer occurs;
  - saturates at TIMEOUT;
  - holds at 0 while word_cnt == 0.
- `flush_pend`:
  - set by FLUSH_REQ when word_cnt != 0, or when a transfer is occurring in that cycle;
  - ignored when word_cnt == 0 with no transfer, so no zero-length packets are sent;
  - cleared on entry to FLUSH.
- FSM:
  - STREAM -> FLUSH when all of: word_cnt != 0, (idle_cnt == TIMEOUT or flush_pend), ok_q, and no transfer this cycle.
  - FLUSH (1 cycle): PKTEND_N=0, SLWR_N=1; word_cnt <= 0; idle_cnt <= 0. Next state is GAP.
  - GAP (1 cycle): DATA_READY=0, PKTEND_N=1. Next state is STREAM.
- Simultaneous events:
  - A transfer takes priority over a flush decision. The flush stays pending and is re-evaluated on the next idle cycle.
  - If that transfer makes word_cnt wrap to 0, the pending flush is dropped (cleared) at wrap.
- FX2 full or not ready: DATA_READY drops one cycle after the flag (registered). The FX2 programmable-full level is configured to absorb this one extra word. A flush waits until ok_q=1.
- TOTAL_WORDS increments by 1 per transfer.

## Timing
- Reset values (asynchronous, effective immediately on STREAM_RST=1):
  - SLWR_N=1, PKTEND_N=1, FIFODATA=0, DATA_READY=0;
  - TOTAL_WORDS=0, word_cnt=0, idle_cnt=0, flush_pend=0, ok_q=0;
  - state=STREAM;
  - FIFOADDR=EP_ADDR at all times.
- First possible DATA_READY: 1 cycle after STREAM_RST deasserts, provided FX2_FULL_N=FX2_RDY=1.
- Latency: accepted word to SLWR_N low is 1 cycle. Full/not-ready flag to DATA_READY low is 1 cycle.
- Timeout flush: last transfer at cycle t; PKTEND_N is low at cycle t+TIMEOUT+2 (counting plus decision plus register), for exactly 1 cycle.
- PKTEND_N and SLWR_N are never low in the same cycle. At least one cycle with both high follows every PKTEND.
- Reset mid-packet discards word_cnt. Any word already strobed stays in the FX2; no PKTEND is issued for it.

## Test plan
- Reset, then 512 back-to-back valid words 0..511 with FX2 always ready -> 512 SLWR_N pulses with data 0..511 in order; PKTEND_N never low; TOTAL_WORDS=512.
- 3 words, then DATA_VALID=0 with TIMEOUT=20 -> exactly one PKTEND_N low pulse, 22 cycles after the last accept; word_cnt returns to 0; no second PKTEND.
- FLUSH_REQ with word_cnt=0, and FLUSH_REQ in the same cycle as the 256th word -> no PKTEND_N pulse in either case.
- 10 words, FLUSH_REQ coincident with the 11th transfer, then idle -> PKTEND_N low 2 cycles after the 11th accept; DATA_READY low during FLUSH and GAP.
- FX2_FULL_N low for 8 cycles mid-burst -> DATA_READY low from the following cycle for 8 cycles; no word lost or duplicated; at most 1 write after the full edge.
- STREAM_RST asserted mid-packet (word_cnt=5, state=FLUSH) -> outputs return to reset values on the same edge; next packet starts at word_cnt 0.
